// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: first-word-fall-through head, one pop per
// rising edge of the transmitter's done signal, sticky overflow/underflow flags.
module uart_tx_fifo #(
   parameter int SIZE_DATA   = 8,
   parameter int DEPTH       = 16,
   parameter int ALMOST_FULL = 14
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_wr_en,
   input  logic [SIZE_DATA-1:0]         i_wr_data,
   input  logic                         i_flush,
   input  logic                         i_clr_err,
   input  logic                         i_tx_done,
   output logic [SIZE_DATA-1:0]         o_tx_data,
   output logic                         o_fifo_empty,
   output logic                         o_full,
   output logic                         o_almost_full,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_overflow,
   output logic                         o_underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(ALMOST_FULL);

   logic [SIZE_DATA-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
   logic                 done_q, done_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   logic                 empty, full, pop, push_ok, pop_ok;
   logic [ADDR_W:0]      count;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
   assign pop     = i_tx_done & ~done_q;
   assign push_ok = i_wr_en & (~full | pop) & ~i_flush;
   assign pop_ok  = pop & ~empty & ~i_flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      done_d      = i_tx_done;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (i_clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         // Setting after clearing lets a same-cycle error win over i_clr_err.
         if (i_wr_en & full & ~pop) overflow_d  = 1'b1;
         if (pop & empty)           underflow_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         done_q      <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_wr_data;
   end

   assign o_tx_data     = mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign o_fifo_empty  = empty;
   assign o_full        = full;
   assign o_almost_full = (count >= AF_LVL);
   assign o_count       = count;
   assign o_overflow    = overflow_q;
   assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a negedge monitor
// compares the head byte whenever a pop edge is presented to a non-empty FIFO.
module tb_uart_tx_fifo;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_wr_en = 1'b0;
   logic [7:0] i_wr_data = '0;
   logic       i_flush = 1'b0;
   logic       i_clr_err = 1'b0;
   logic       i_tx_done = 1'b1;
   logic [7:0] o_tx_data;
   logic       o_fifo_empty, o_full, o_almost_full, o_overflow, o_underflow;
   logic [4:0] o_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];
   logic       prev_done = 1'b1;

   uart_tx_fifo #(.SIZE_DATA(8), .DEPTH(16), .ALMOST_FULL(14)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
      .i_flush(i_flush), .i_clr_err(i_clr_err), .i_tx_done(i_tx_done),
      .o_tx_data(o_tx_data), .o_fifo_empty(o_fifo_empty), .o_full(o_full),
      .o_almost_full(o_almost_full), .o_count(o_count),
      .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: a rising done edge on a non-empty FIFO hands the head byte to the transmitter.
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_done = 1'b1;
      end else begin
         if (i_tx_done && !prev_done && !o_fifo_empty && !i_flush) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underrun actual=%0h expected=none", o_tx_data);
            end else begin
               check("pop_data", o_tx_data, sb.pop_front());
            end
         end
         prev_done = i_tx_done;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input bit accept);
      i_wr_en   = 1'b1;
      i_wr_data = b;
      if (accept) sb.push_back(b);
      tick();
      i_wr_en = 1'b0;
   endtask

   task automatic done_pulse();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with done held high; releasing reset must not pop.
      #1;
      repeat (3) tick();
      i_rst = 1'b0;
      tick();
      tick();
      check("rst_count", o_count, 0);
      check("rst_empty", o_fifo_empty, 1);
      check("rst_full", o_full, 0);
      check("rst_afull", o_almost_full, 0);
      check("rst_no_underflow", o_underflow, 0);
      i_tx_done = 1'b0;
      tick();
      check("rst_overflow", o_overflow, 0);

      // Basic FWFT order.
      push(8'h29, 1'b1);
      check("fwft_head", o_tx_data, 8'h29);
      check("fwft_not_empty", o_fifo_empty, 0);
      push(8'hA5, 1'b1);
      push(8'h3C, 1'b1);
      check("three_count", o_count, 3);
      repeat (3) done_pulse();
      check("three_empty", o_fifo_empty, 1);

      // Fill to full, then an overflowing 17th push.
      for (int i = 0; i < 16; i++) begin
         push(8'h10 + 8'(i), 1'b1);
         if (i == 12) check("afull_at13", o_almost_full, 0);
         if (i == 13) begin
            check("afull_at14", o_almost_full, 1);
            check("full_at14", o_full, 0);
         end
      end
      check("full_count", o_count, 16);
      check("full_flag", o_full, 1);
      push(8'hEE, 1'b0);
      check("ovf_set", o_overflow, 1);
      check("ovf_head", o_tx_data, 8'h10);
      check("ovf_count", o_count, 16);

      // Full with simultaneous push and pop edge.
      i_wr_en   = 1'b1;
      i_wr_data = 8'h55;
      i_tx_done = 1'b1;
      sb.push_back(8'h55);
      tick();
      i_wr_en   = 1'b0;
      i_tx_done = 1'b0;
      check("fullpp_count", o_count, 16);
      check("fullpp_full", o_full, 1);
      tick();
      repeat (15) done_pulse();
      check("fullpp_last_count", o_count, 1);
      check("fullpp_last_head", o_tx_data, 8'h55);
      done_pulse();
      check("fullpp_drained", o_fifo_empty, 1);
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      check("ovf_cleared", o_overflow, 0);

      // Held done level pops only once.
      push(8'hA1, 1'b1);
      push(8'hB2, 1'b1);
      push(8'hC3, 1'b1);
      i_tx_done = 1'b1;
      repeat (10) tick();
      i_tx_done = 1'b0;
      check("level_one_pop", o_count, 2);
      tick();
      repeat (2) done_pulse();
      check("level_empty", o_fifo_empty, 1);
      done_pulse();
      check("udf_set", o_underflow, 1);
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      check("udf_cleared", o_underflow, 0);

      // Push and pop edge on an empty FIFO: push only, underflow set.
      i_wr_en   = 1'b1;
      i_wr_data = 8'h77;
      i_tx_done = 1'b1;
      sb.push_back(8'h77);
      tick();
      i_wr_en   = 1'b0;
      i_tx_done = 1'b0;
      check("emptypp_count", o_count, 1);
      check("emptypp_udf", o_underflow, 1);
      tick();
      done_pulse();
      check("emptypp_drained", o_fifo_empty, 1);

      // Interleaved traffic across the pointer wrap, then a flush.
      push(8'h40, 1'b1);
      for (int i = 1; i < 20; i++) begin
         i_wr_en   = 1'b1;
         i_wr_data = 8'h40 + 8'(i);
         i_tx_done = 1'b1;
         sb.push_back(8'h40 + 8'(i));
         tick();
         i_wr_en   = 1'b0;
         i_tx_done = 1'b0;
         tick();
      end
      check("wrap_count", o_count, 1);
      check("wrap_head", o_tx_data, 8'h53);
      push(8'h60, 1'b0);
      push(8'h61, 1'b0);
      check("preflush_count", o_count, 3);
      i_flush   = 1'b1;
      i_wr_en   = 1'b1;
      i_wr_data = 8'h99;
      tick();
      i_flush = 1'b0;
      i_wr_en = 1'b0;
      sb.delete();
      check("flush_count", o_count, 0);
      check("flush_empty", o_fifo_empty, 1);
      check("flush_udf_kept", o_underflow, 1);
      check("flush_ovf_kept", o_overflow, 0);
      push(8'h5A, 1'b1);
      check("postflush_head", o_tx_data, 8'h5A);
      done_pulse();
      check("postflush_empty", o_fifo_empty, 1);

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
